// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//
// Merges register-file writes from two requesters into the single write port
// of the register file:
//   A = ALU writeback, B = load unit.
// Each requester has a 1-entry holding buffer. A request is accepted on a
// clock edge where req_x & ready_x. In each cycle, at most one full buffer is
// granted. The granted write appears on the write port in the following cycle.
// Writes that target register 7 (zero) are discarded and counted.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous active-high reset
//   req_a / req_b       write request
//   sel_a / sel_b [2:0] destination register index (7 = zero, discarded)
//   data_a / data_b [9:0] write data
//   ready_a / ready_b   holding buffer empty (combinational from the full flag)
//   gb_en               register file write enable (registered)
//   write_sel [2:0]     register file write index (registered)
//   rs_write [9:0]      register file write data (registered)
//   drop_cnt [3:0]      saturating count of discarded writes to register 7
//
// Configuration
//   REG_ARB_ROUND_ROBIN_EN  defined   : on contention, grant the requester not
//                                       granted most recently
//   REG_ARB_ROUND_ROBIN_EN  undefined : fixed priority, A over B

module reg_write_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [2:0] sel_a,
  input  logic [2:0] sel_b,
  input  logic [9:0] data_a,
  input  logic [9:0] data_b,
  output logic       ready_a,
  output logic       ready_b,
  output logic       gb_en,
  output logic [2:0] write_sel,
  output logic [9:0] rs_write,
  output logic [3:0] drop_cnt
);

  localparam logic [2:0] SEL_ZERO = 3'd7;

  logic       full_a_r;
  logic       full_b_r;
  logic [2:0] sel_a_r;
  logic [2:0] sel_b_r;
  logic [9:0] data_a_r;
  logic [9:0] data_b_r;

  logic       grant_a_s;
  logic       grant_b_s;
  logic       grant_any_s;
  logic [2:0] grant_sel_s;
  logic [9:0] grant_data_s;

`ifdef REG_ARB_ROUND_ROBIN_EN
  // 1 = B was granted most recently, 0 = A.
  logic       last_b_r;
`endif

  assign ready_a = ~full_a_r;
  assign ready_b = ~full_b_r;

  // Grant selection among full buffers.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
`ifdef REG_ARB_ROUND_ROBIN_EN
    if (full_a_r && full_b_r) begin
      // On contention, favour the requester that was not served last.
      grant_a_s = last_b_r;
      grant_b_s = ~last_b_r;
    end else begin
      grant_a_s = full_a_r;
      grant_b_s = full_b_r;
    end
`else
    if (full_a_r) begin
      grant_a_s = 1'b1;
      grant_b_s = 1'b0;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = full_b_r;
    end
`endif
  end

  // Mux the granted buffer's contents toward the output registers.
  always_comb begin
    grant_any_s  = grant_a_s | grant_b_s;
    grant_sel_s  = 3'd0;
    grant_data_s = 10'd0;
    if (grant_a_s) begin
      grant_sel_s  = sel_a_r;
      grant_data_s = data_a_r;
    end else if (grant_b_s) begin
      grant_sel_s  = sel_b_r;
      grant_data_s = data_b_r;
    end else begin
      grant_sel_s  = 3'd0;
      grant_data_s = 10'd0;
    end
  end

  // Holding buffer for requester A.
  // Acceptance and grant are mutually exclusive, because ready is ~full.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_a_r <= 1'b0;
      sel_a_r  <= 3'd0;
      data_a_r <= 10'd0;
    end else if (req_a && !full_a_r) begin
      full_a_r <= 1'b1;
      sel_a_r  <= sel_a;
      data_a_r <= data_a;
    end else if (grant_a_s) begin
      full_a_r <= 1'b0;
    end else begin
      full_a_r <= full_a_r;
    end
  end

  // Holding buffer for requester B.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_b_r <= 1'b0;
      sel_b_r  <= 3'd0;
      data_b_r <= 10'd0;
    end else if (req_b && !full_b_r) begin
      full_b_r <= 1'b1;
      sel_b_r  <= sel_b;
      data_b_r <= data_b;
    end else if (grant_b_s) begin
      full_b_r <= 1'b0;
    end else begin
      full_b_r <= full_b_r;
    end
  end

  // Register-file write port and drop counter.
  // write_sel and rs_write hold their values when there is no write.
  always_ff @(posedge clk) begin
    if (reset) begin
      gb_en     <= 1'b0;
      write_sel <= 3'd0;
      rs_write  <= 10'd0;
      drop_cnt  <= 4'd0;
    end else if (grant_any_s) begin
      if (grant_sel_s == SEL_ZERO) begin
        gb_en <= 1'b0;
        if (drop_cnt != 4'd15) begin
          drop_cnt <= drop_cnt + 4'd1;
        end else begin
          drop_cnt <= drop_cnt;
        end
      end else begin
        gb_en     <= 1'b1;
        write_sel <= grant_sel_s;
        rs_write  <= grant_data_s;
      end
    end else begin
      gb_en <= 1'b0;
    end
  end

`ifdef REG_ARB_ROUND_ROBIN_EN
  // Last-grant tracking.
  // This is updated on every grant, including drops to register 7.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_r <= 1'b1;
    end else if (grant_a_s) begin
      last_b_r <= 1'b0;
    end else if (grant_b_s) begin
      last_b_r <= 1'b1;
    end else begin
      last_b_r <= last_b_r;
    end
  end
`endif

endmodule
